i2f16: RTL
==========

# i2f16

Pipelined integer-to-half-precision converter: accepts a signed or unsigned integer of parameterized width and produces an IEEE 754 binary16 value, rounded to nearest-even. Sits in the FP16 unit beside the float-to-integer converter and provides the opposite direction of the same conversion path. Three-stage pipeline with clock enable and a valid tag, one conversion per enabled cycle.

## Interface
- `WID`, 16: input integer width; legal range 2..32.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset; **synchronous, active-low**.
- `ce` input 1: clock enable; when low, every pipeline register holds.
- `ld` input 1: input valid; sampled when `ce`=1.
- `op` input 1: 1 = `i` is two's-complement signed, 0 = unsigned.
- `i` input WID: integer operand.
- `o` output 16: FP16 result `{sign, exp[4:0], frac[9:0]}`, exponent bias 15.
- `done` output 1: `o` holds a completed conversion.
- `overflow` output 1: rounded magnitude ≥ 65520; `o` is ±infinity.
- `inexact` output 1: present only with `I2F16_INEXACT_EN`; rounding discarded nonzero bits.

## Operation
- **Stage 1 (S1), sign/magnitude.**
  - `sgn = op & i[WID-1]`.
  - `mag = sgn ? -i : i`, held WID bits wide and treated as unsigned, so -2^(WID-1) yields magnitude 2^(WID-1).
  - `zero = (i == 0)`.
- **Stage 2 (S2), normalize.**
  - Leading-zero count `lz` of `mag`.
  - `norm = mag << lz`, so the MSB is the hidden bit.
  - Unbiased exponent `e = WID-1-lz`.
- **Stage 3 (S3), round and pack.**
  - From `norm`: mantissa M = 11 bits below and including the MSB, guard G = next bit, sticky S = OR of all remaining bits. For WID ≤ 11, G = S = 0.
  - Round up when `G & (S | M[0])`.
  - If the increment carries out of M (M = 0x7FF), the mantissa becomes 0x400 and `e` increments.
  - Biased exponent = `e + 15`. If biased exponent ≥ 31: `o = {sgn, 5'h1F, 10'h0}`, `overflow = 1`.
  - Otherwise `o = {sgn, e+15, M[9:0]}`.
  - `zero` forces `o = 16'h0000`, `overflow = 0`. Signed zero never occurs.
  - No subnormal outputs are possible: the smallest nonzero result is 1.0.
- **Valid tag.** `ld` propagates S1→S2→S3 alongside the data. `done` is the S3 tag. When `ld` = 0, the data registers may load don't-care values, but `done` must be 0.

## Timing
- **Latency:** 3 enabled cycles. Operands presented at enabled edge N appear on `o`/`done` after enabled edge N+2, i.e. valid in the cycle following the third `ce`=1 edge that includes the load edge.
- **Throughput:** one operand per enabled cycle; back-to-back `ld` is legal.
- **`ce` = 0:** all stages, including the valid tags, hold. `done` and `o` stay static. A held `done` = 1 represents the same single result, not a new one.
- **Reset:** `rst_n` = 0 at a clock edge clears all valid tags and all S3 registers, regardless of `ce`. After reset, `o` = 0, `done` = 0, `overflow` = 0, `inexact` = 0.
- **Reset mid-operation:** in-flight conversions are discarded. No `done` is produced for them.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`I2F16_INEXACT_EN` defined:**
  - The `inexact` port and a pipelined flag are present.
  - `inexact = G | S | overflow` for the S3 operand, and 0 when `zero`.
  - The flag is registered with the S3 data and obeys the same `ce` and reset rules.
- **`I2F16_INEXACT_EN` undefined:**
  - The port and its logic are omitted entirely.
  - All other behaviour is identical.

## Test plan
- **Basic values** (WID = 16, op = 1): `i` = 0x0001 → `o` = 0x3C00; `i` = 0xFFFF → `o` = 0xBC00; `i` = 0x0000 → `o` = 0x0000. In each case `done` = 1 exactly 3 enabled cycles after `ld`.
- **Most negative** (op = 1): `i` = 0x8000 → `o` = 0xF800, `overflow` = 0. Same `i` with op = 0 (32768) → `o` = 0x7800.
- **Rounding** (op = 0):
  - `i` = 2049 → `o` = 0x6800 (tie to even), `inexact` = 1.
  - `i` = 2051 → `o` = 0x6802 (tie, rounds up).
  - `i` = 2050 → `o` = 0x6801, `inexact` = 0.
- **Overflow** (op = 0):
  - `i` = 0xFFFF → `o` = 0x7C00, `overflow` = 1.
  - `i` = 65504 → `o` = 0x7BFF, `overflow` = 0.
  - WID = 32, op = 0, `i` = 65519 → `o` = 0x7BFF; `i` = 65520 → `o` = 0x7C00, `overflow` = 1.
- **Stall / throughput:**
  - Stream 1, 2, 3 on consecutive cycles → results 0x3C00, 0x4000, 0x4200 on consecutive cycles.
  - Repeat with `ce` = 0 for 2 cycles mid-stream → outputs freeze and no results are lost or duplicated.
- **Reset mid-flight:** load 2 operands, assert `rst_n` = 0 for one edge → `done` = 0 on the next cycle and all outputs = 0. No stale result emerges afterward.

Source files
------------

// File: rtl/i2f16.sv
// i2f16: three-stage pipelined integer to IEEE 754 binary16 converter.
// S1 takes sign and magnitude, S2 normalizes, S3 rounds to nearest-even and packs.
// The optional `inexact` output is enabled by defining I2F16_INEXACT_EN.
// Zero is detected in S3 from the missing hidden bit of the normalized value.
// That bit is clear exactly when the operand was zero, so no separate zero
// tag has to travel down the pipeline.
module i2f16 #(
    parameter int WID = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           ld,
    input  logic           op,
    input  logic [WID-1:0] i,
    output logic [15:0]    o,
    output logic           done,
    output logic           overflow
`ifdef I2F16_INEXACT_EN
    ,
    output logic           inexact
`endif
);

    // A WID-bit value has up to WID leading zeros.
    localparam int LZW = $clog2(WID + 1);

    // S1 registers
    logic           v1_q, v1_d;
    logic           sgn1_q, sgn1_d;
    logic [WID-1:0] mag_q, mag_d;

    // S2 registers
    logic           v2_q, v2_d;
    logic           sgn2_q, sgn2_d;
    logic [WID-1:0] norm_q, norm_d;
    logic [5:0]     e_q, e_d;
    logic [LZW-1:0] lz_d;

    // S3 registers (the outputs)
    logic           done_q, done_d;
    logic [15:0]    o_q, o_d;
    logic           ovf_q, ovf_d;
    logic           inx_q, inx_d;

    // S3 datapath intermediates
    logic [WID+11:0] ext;
    logic [10:0]     mant;
    logic            g_bit;
    logic            s_bit;
    logic            rnd;
    logic            carry;
    logic [9:0]      frac;
    logic [6:0]      exp_b;

    // S1: split the operand into sign and unsigned magnitude
    always_comb begin
        v1_d   = ld;
        sgn1_d = op & i[WID-1];
        // The most negative value wraps to 2^(WID-1), which is correct unsigned.
        mag_d  = sgn1_d ? -i : i;
    end

    // S2: leading-zero count, normalize so the MSB is the hidden bit
    always_comb begin
        v2_d   = v1_q;
        sgn2_d = sgn1_q;
        lz_d   = LZW'(WID);
        // The highest set bit is visited last, so it decides the count.
        for (int k = 0; k < WID; k++) begin
            if (mag_q[k]) begin
                lz_d = LZW'(WID - 1 - k);
            end
        end
        norm_d = mag_q << lz_d;
        // Wraps for a zero operand; S3 ignores the exponent in that case.
        e_d    = 6'(WID - 1) - 6'(lz_d);
    end

    // S3: pick mantissa/guard/sticky, round to nearest-even, pack or saturate
    always_comb begin
        // Padding with 12 zeros keeps every slice legal for narrow widths;
        // for WID <= 11 the guard and sticky then fall on the padding.
        ext   = {norm_q, 12'b0};
        mant  = ext[WID+11:WID+1];
        g_bit = ext[WID];
        s_bit = |ext[WID-1:0];
        rnd   = g_bit & (s_bit | mant[0]);
        // The hidden bit is always 1, so a carry out of the 10 fraction bits
        // is the mantissa overflowing to 2.0; the fraction is then already 0.
        {carry, frac} = {1'b0, mant[9:0]} + 11'(rnd);
        exp_b = 7'(e_q) + 7'(carry) + 7'd15;

        done_d = v2_q;
        o_d    = 16'h0000;
        ovf_d  = 1'b0;
        inx_d  = 1'b0;
        if (mant[10]) begin
            if (exp_b >= 7'd31) begin
                o_d   = {sgn2_q, 5'h1F, 10'h000};
                ovf_d = 1'b1;
                inx_d = 1'b1;
            end else begin
                o_d   = {sgn2_q, exp_b[4:0], frac};
                inx_d = g_bit | s_bit;
            end
        end
    end

    // S1/S2 data registers: no reset needed, contents are qualified by the tags
    always_ff @(posedge clk) begin
        if (ce) begin
            sgn1_q <= sgn1_d;
            mag_q  <= mag_d;
            sgn2_q <= sgn2_d;
            norm_q <= norm_d;
            e_q    <= e_d;
        end
    end

    // Valid tags and S3 registers: reset wins over ce, otherwise hold when ce is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            done_q <= 1'b0;
            o_q    <= 16'h0000;
            ovf_q  <= 1'b0;
            inx_q  <= 1'b0;
        end else if (ce) begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            done_q <= done_d;
            o_q    <= o_d;
            ovf_q  <= ovf_d;
            inx_q  <= inx_d;
        end
    end

    assign o        = o_q;
    assign done     = done_q;
    assign overflow = ovf_q;
`ifdef I2F16_INEXACT_EN
    assign inexact  = inx_q;
`endif

endmodule
